// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        STG_EMPTY,
        STG_FULL
    } stage_state_t;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver with frame-aligned load commit.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_digits,
    input  logic [3:0]  ld_blank,
    input  logic [3:0]  ld_dp,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    digit_idx_t    idx;
    digit_idx_t    idx_n;
    logic          tick;
    logic          accept;
    logic          commit;

    stage_state_t  stg_state;
    stage_state_t  stg_next;
    logic [15:0]   stg_digits;
    logic [3:0]    stg_blank;
    logic [3:0]    stg_dp;

    logic [15:0]   act_digits;
    logic [3:0]    act_blank;
    logic [3:0]    act_dp;
    logic [15:0]   act_digits_n;
    logic [3:0]    act_blank_n;
    logic [3:0]    act_dp_n;

    logic [3:0]    lzb_mask;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;

    assign tick     = (presc == PRESC_LAST);
    assign idx_n    = tick ? idx + 2'd1 : idx;
    assign frame    = tick && (idx == 2'd3);
    assign ld_ready = (stg_state == STG_EMPTY);
    assign accept   = ld_valid && ld_ready;
    assign commit   = frame && (stg_state == STG_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_state <= STG_EMPTY;
        end else begin
            stg_state <= stg_next;
        end
    end

    always_comb begin
        stg_next = stg_state;
        case (stg_state)
            STG_EMPTY: if (ld_valid) stg_next = STG_FULL;
            STG_FULL:  if (frame)    stg_next = STG_EMPTY;
            default:                 stg_next = STG_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_digits <= '0;
            stg_blank  <= AN_OFF;
            stg_dp     <= '0;
        end else if (accept) begin
            stg_digits <= ld_digits;
            stg_blank  <= ld_blank;
            stg_dp     <= ld_dp;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit goes dark only when it and every digit to its left are zero.
    assign lzb_mask = {stg_digits[15:12] == 4'd0,
                       stg_digits[15:8]  == 8'd0,
                       stg_digits[15:4]  == 12'd0,
                       1'b0};
`else
    assign lzb_mask = 4'b0000;
`endif

    always_comb begin
        act_digits_n = act_digits;
        act_blank_n  = act_blank;
        act_dp_n     = act_dp;
        if (commit) begin
            act_digits_n = stg_digits;
            act_blank_n  = stg_blank | lzb_mask;
            act_dp_n     = stg_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_digits <= '0;
            act_blank  <= AN_OFF;
            act_dp     <= '0;
        end else begin
            act_digits <= act_digits_n;
            act_blank  <= act_blank_n;
            act_dp     <= act_dp_n;
        end
    end

    // Mux from next-cycle index and data so the registered outputs track the tick.
    assign nib = act_digits_n[{idx_n, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .nibble (nib),
        .seg_n  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
            dp  <= 1'b1;
        end else begin
            if (act_blank_n[idx_n]) begin
                seg <= SEG_OFF;
                an  <= AN_OFF;
            end else begin
                seg <= seg_dec;
                an  <= ~(4'b0001 << idx_n);
            end
            dp <= ~act_dp_n[idx_n];
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with REFRESH_DIV = 4.
// Leading-zero expectations follow SEG_SCAN_LZB_EN when it is defined.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_digits;
    logic [3:0]  ld_blank;
    logic [3:0]  ld_dp;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_digits (ld_digits),
        .ld_blank  (ld_blank),
        .ld_dp     (ld_dp),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .frame     (frame)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkSlot(input string tag, input logic [6:0] eseg, input logic [3:0] ean, input logic edp);
        checkOutput({tag, "_seg"}, {9'd0, seg}, {9'd0, eseg});
        checkOutput({tag, "_an"}, {12'd0, an}, {12'd0, ean});
        checkOutput({tag, "_dp"}, {15'd0, dp}, {15'd0, edp});
    endtask

    task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] blank, input logic [3:0] dpm);
        ld_valid  = 1'b1;
        ld_digits = digits;
        ld_blank  = blank;
        ld_dp     = dpm;
        step();
        ld_valid  = 1'b0;
    endtask

    task automatic waitFrame();
        int n = 0;
        while (frame !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checkOutput("frame_seen", {15'd0, frame}, 16'd1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_digits = '0;
        ld_blank  = '0;
        ld_dp     = '0;
        stepN(3);
        checkSlot("reset", 7'h7F, 4'hF, 1'b1);
        checkOutput("reset_ready", {15'd0, ld_ready}, 16'd1);
        checkOutput("reset_frame", {15'd0, frame}, 16'd0);
        rst = 1'b0;

        // Idle after reset: dark display, frame every 16 cycles.
        for (int i = 0; i < 40; i++) begin
            checkSlot("idle", 7'h7F, 4'hF, 1'b1);
            checkOutput("idle_ready", {15'd0, ld_ready}, 16'd1);
            checkOutput("idle_frame", {15'd0, frame}, {15'd0, (i % 16) == 15});
            step();
        end

        // Basic load 3A07 with DP on digit 2.
        applyStimulus(16'h3A07, 4'b0000, 4'b0100);
        checkOutput("load_ready_low", {15'd0, ld_ready}, 16'd0);
        waitFrame();
        checkOutput("commit_ready_low", {15'd0, ld_ready}, 16'd0);
        step();
        checkOutput("post_commit_ready", {15'd0, ld_ready}, 16'd1);
        checkSlot("d0_7", 7'h0F, 4'b1110, 1'b1);
        stepN(4);
        checkSlot("d1_0", 7'h01, 4'b1101, 1'b1);
        stepN(4);
        checkSlot("d2_A", 7'h08, 4'b1011, 1'b0);
        stepN(4);
        checkSlot("d3_3", 7'h06, 4'b0111, 1'b1);

        // Back-to-back: 1111 accepted, 2222 held until ready returns.
        ld_valid  = 1'b1;
        ld_digits = 16'h1111;
        step();
        ld_digits = 16'h2222;
        n = 0;
        while (frame !== 1'b1 && n < 40) begin
            checkOutput("hold_ready", {15'd0, ld_ready}, 16'd0);
            step();
            n++;
        end
        checkOutput("hold_frame", {15'd0, frame}, 16'd1);
        checkOutput("hold_ready_commit", {15'd0, ld_ready}, 16'd0);
        step();
        checkOutput("hold_ready_back", {15'd0, ld_ready}, 16'd1);
        checkSlot("b2b_1111", 7'h4F, 4'b1110, 1'b1);
        step();
        ld_valid = 1'b0;
        checkOutput("b2b_2222_pending", {15'd0, ld_ready}, 16'd0);
        stepN(3);
        checkSlot("b2b_1111_d1", 7'h4F, 4'b1101, 1'b1);
        waitFrame();
        step();
        checkSlot("b2b_2222", 7'h12, 4'b1110, 1'b1);

        // Load offered exactly on the commit cycle is refused.
        applyStimulus(16'h89AB, 4'b0100, 4'b0001);
        waitFrame();
        ld_valid  = 1'b1;
        ld_digits = 16'h4567;
        ld_blank  = 4'b0000;
        ld_dp     = 4'b0000;
        checkOutput("commit_offer_ready", {15'd0, ld_ready}, 16'd0);
        step();
        checkOutput("commit_offer_next_ready", {15'd0, ld_ready}, 16'd1);
        checkSlot("c_dB", 7'h60, 4'b1110, 1'b0);
        step();
        ld_valid = 1'b0;
        checkOutput("commit_offer_taken", {15'd0, ld_ready}, 16'd0);
        stepN(3);
        checkSlot("c_dA", 7'h08, 4'b1101, 1'b1);
        stepN(4);
        checkSlot("c_blank2", 7'h7F, 4'hF, 1'b1);
        waitFrame();
        step();
        checkSlot("c_d7", 7'h0F, 4'b1110, 1'b1);
        stepN(4);
        checkSlot("c_d6", 7'h20, 4'b1101, 1'b1);

        // Reset mid-frame with a load pending.
        applyStimulus(16'hDEAD, 4'b0000, 4'b1111);
        step();
        rst = 1'b1;
        step();
        checkSlot("midrst", 7'h7F, 4'hF, 1'b1);
        checkOutput("midrst_ready", {15'd0, ld_ready}, 16'd1);
        checkOutput("midrst_frame", {15'd0, frame}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            checkSlot("midrst_dark", 7'h7F, 4'hF, 1'b1);
            step();
        end

        // Leading-zero blanking.
        applyStimulus(16'h0050, 4'b0000, 4'b0000);
        waitFrame();
        step();
        checkSlot("lz50_d0", 7'h01, 4'b1110, 1'b1);
        stepN(4);
        checkSlot("lz50_d1", 7'h24, 4'b1101, 1'b1);
        stepN(4);
`ifdef SEG_SCAN_LZB_EN
        checkSlot("lz50_d2", 7'h7F, 4'hF, 1'b1);
        stepN(4);
        checkSlot("lz50_d3", 7'h7F, 4'hF, 1'b1);
`else
        checkSlot("lz50_d2", 7'h01, 4'b1011, 1'b1);
        stepN(4);
        checkSlot("lz50_d3", 7'h01, 4'b0111, 1'b1);
`endif
        applyStimulus(16'h0000, 4'b0000, 4'b0000);
        waitFrame();
        step();
        checkSlot("lz00_d0", 7'h01, 4'b1110, 1'b1);
        stepN(4);
`ifdef SEG_SCAN_LZB_EN
        checkSlot("lz00_d1", 7'h7F, 4'hF, 1'b1);
`else
        checkSlot("lz00_d1", 7'h01, 4'b1101, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
